// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: holds the current round key and advances one round
// per request, pushing RotWord(w3) through a single shared S-box one byte per cycle.
module key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic         next_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         busy,
  output logic         last_round
);

  typedef enum logic [1:0] {StIdle, StReady, StSub, StXor} state_e;

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   num_q, num_d;
  logic         valid_q, valid_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  temp_q, temp_d;

  logic [31:0] rot_w3;
  logic [7:0]  sbox_in, sbox_out;
  logic [3:0]  num_inc;
  logic [7:0]  rcon;
  logic [31:0] t_word, w0_n, w1_n, w2_n, w3_n;

  assign rot_w3   = {key_q[23:0], key_q[31:24]};
  assign sbox_out = Sbox[sbox_in];
  assign num_inc  = num_q + 4'd1;

  // Byte 0 is the MSB of the rotated word.
  always_comb begin
    sbox_in = 8'h00;
    unique case (cnt_q)
      2'd0: sbox_in = rot_w3[31:24];
      2'd1: sbox_in = rot_w3[23:16];
      2'd2: sbox_in = rot_w3[15:8];
      2'd3: sbox_in = rot_w3[7:0];
      default: sbox_in = 8'h00;
    endcase
  end

  // rcon is indexed by the round number being produced.
  always_comb begin
    rcon = 8'h00;
    case (num_inc)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_word = temp_q ^ {rcon, 24'h000000};
  assign w0_n   = key_q[127:96] ^ t_word;
  assign w1_n   = key_q[95:64] ^ w0_n;
  assign w2_n   = key_q[63:32] ^ w1_n;
  assign w3_n   = key_q[31:0] ^ w2_n;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    if (key_load) begin
      key_d   = cipher_key;
      num_d   = 4'd0;
      valid_d = 1'b1;
      cnt_d   = 2'd0;
      state_d = StReady;
    end else begin
      case (state_q)
        StIdle: ;
        StReady: begin
          if (next_key && (num_q < 4'd10)) begin
            valid_d = 1'b0;
            cnt_d   = 2'd0;
            state_d = StSub;
          end
        end
        StSub: begin
          unique case (cnt_q)
            2'd0: temp_d[31:24] = sbox_out;
            2'd1: temp_d[23:16] = sbox_out;
            2'd2: temp_d[15:8]  = sbox_out;
            2'd3: temp_d[7:0]   = sbox_out;
            default: ;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StXor;
        end
        StXor: begin
          key_d   = {w0_n, w1_n, w2_n, w3_n};
          num_d   = num_inc;
          valid_d = 1'b1;
          state_d = StReady;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      temp_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
    end
  end

  assign round_key  = key_q;
  assign round_num  = num_q;
  assign key_valid  = valid_q;
  assign busy       = (state_q == StSub) || (state_q == StXor);
  assign last_round = (num_q == 4'd10) && valid_q;

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: FIPS-197 vectors plus random keys checked against a
// reference schedule whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_key_expansion;

  logic         clk;
  logic         rst;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         next_key;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         last_round;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] sb_ref [256];

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsR2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  key_expansion dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .cipher_key (cipher_key),
    .next_key   (next_key),
    .round_key  (round_key),
    .round_num  (round_num),
    .key_valid  (key_valid),
    .busy       (busy),
    .last_round (last_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_ref[tmp[31:24]], sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]]};
        tmp ^= {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    cipher_key = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  // Pulses next_key for one cycle; lat = edges until key_valid returns (20 = timeout).
  task automatic do_advance(output int lat);
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    lat = 0;
    while (key_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (round_key !== 128'h0) $display("FAIL reset_key: got %h want 0", round_key);
    else pass_cnt++;
    total_cnt++;
    if (round_num !== 4'd0) $display("FAIL reset_num: got %0d want 0", round_num);
    else pass_cnt++;
    total_cnt++;
    if ({key_valid, busy, last_round} !== 3'b000)
      $display("FAIL reset_flags: got v%b b%b l%b want 000", key_valid, busy, last_round);
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fips_vector();
    int lat;
    load_key(FipsKey);
    total_cnt++;
    if (round_key !== FipsKey || round_num !== 4'd0)
      $display("FAIL fips_load: got %h r%0d want %h r0", round_key, round_num, FipsKey);
    else pass_cnt++;
    total_cnt++;
    if ({key_valid, busy, last_round} !== 3'b100)
      $display("FAIL fips_load_flags: got v%b b%b l%b want 100", key_valid, busy, last_round);
    else pass_cnt++;
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if (key_valid !== 1'b0 || busy !== 1'b1 || round_key !== FipsKey)
        $display("FAIL fips_busy_c%0d: got v%b b%b key %h want v0 b1 key %h",
                 c, key_valid, busy, round_key, FipsKey);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (round_key !== FipsR1 || round_num !== 4'd1 || key_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL fips_r1: got %h r%0d v%b b%b want %h r1 v1 b0",
               round_key, round_num, key_valid, busy, FipsR1);
    else pass_cnt++;
    do_advance(lat);
    total_cnt++;
    if (lat !== 5 || round_key !== FipsR2 || round_num !== 4'd2)
      $display("FAIL fips_r2: got %h r%0d lat %0d want %h r2 lat 5",
               round_key, round_num, lat, FipsR2);
    else pass_cnt++;
  endtask

  task automatic test_all_rounds();
    int lat;
    load_key(FipsKey);
    for (int r = 1; r <= 10; r++) begin
      do_advance(lat);
      total_cnt++;
      if (lat !== 5 || round_key !== ref_key(FipsKey, r) || round_num !== 4'(r))
        $display("FAIL all_rounds_r%0d: got %h r%0d lat %0d want %h r%0d lat 5",
                 r, round_key, round_num, lat, ref_key(FipsKey, r), r);
      else pass_cnt++;
    end
    total_cnt++;
    if (round_key !== FipsR10 || last_round !== 1'b1)
      $display("FAIL all_rounds_r10: got %h l%b want %h l1", round_key, last_round, FipsR10);
    else pass_cnt++;
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    for (int i = 0; i < 7; i++) begin
      total_cnt++;
      if (round_key !== FipsR10 || round_num !== 4'd10 || key_valid !== 1'b1 || busy !== 1'b0)
        $display("FAIL eleventh_ignored: got %h r%0d v%b b%b want %h r10 v1 b0",
                 round_key, round_num, key_valid, busy, FipsR10);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_random_keys();
    int lat;
    logic [127:0] k;
    repeat (4) begin
      k = rand_key();
      load_key(k);
      for (int r = 1; r <= 10; r++) begin
        do_advance(lat);
        total_cnt++;
        if (lat !== 5 || round_key !== ref_key(k, r) || round_num !== 4'(r) ||
            last_round !== (r == 10))
          $display("FAIL random_r%0d: key %h got %h r%0d l%b lat %0d want %h",
                   r, k, round_key, round_num, last_round, lat, ref_key(k, r));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_next_during_sub();
    int lat;
    logic [127:0] k;
    k = rand_key();
    load_key(k);
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    step();
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    lat = 0;
    while (key_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    total_cnt++;
    if (round_num !== 4'd1 || round_key !== ref_key(k, 1))
      $display("FAIL sub_pulse_advance: got %h r%0d want %h r1", round_key, round_num,
               ref_key(k, 1));
    else pass_cnt++;
    repeat (8) step();
    total_cnt++;
    if (round_num !== 4'd1 || busy !== 1'b0 || key_valid !== 1'b1)
      $display("FAIL sub_pulse_not_queued: got r%0d b%b v%b want r1 b0 v1",
               round_num, busy, key_valid);
    else pass_cnt++;
  endtask

  task automatic test_load_abort();
    int lat;
    logic [127:0] k, k2;
    k = rand_key();
    k2 = rand_key();
    load_key(k);
    do_advance(lat);
    do_advance(lat);
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    step();
    step();
    load_key(k2);
    total_cnt++;
    if (round_num !== 4'd0 || round_key !== k2 || busy !== 1'b0 || key_valid !== 1'b1)
      $display("FAIL abort_load: got %h r%0d b%b v%b want %h r0 b0 v1",
               round_key, round_num, busy, key_valid, k2);
    else pass_cnt++;
    do_advance(lat);
    total_cnt++;
    if (lat !== 5 || round_key !== ref_key(k2, 1) || round_num !== 4'd1)
      $display("FAIL abort_then_advance: got %h r%0d lat %0d want %h r1 lat 5",
               round_key, round_num, lat, ref_key(k2, 1));
    else pass_cnt++;
  endtask

  task automatic test_load_and_next();
    int lat;
    logic [127:0] k, k3;
    k = rand_key();
    k3 = rand_key();
    load_key(k);
    do_advance(lat);
    cipher_key = k3;
    key_load = 1'b1;
    next_key = 1'b1;
    step();
    key_load = 1'b0;
    next_key = 1'b0;
    total_cnt++;
    if (round_num !== 4'd0 || round_key !== k3 || busy !== 1'b0 || key_valid !== 1'b1)
      $display("FAIL load_wins: got %h r%0d b%b v%b want %h r0 b0 v1",
               round_key, round_num, busy, key_valid, k3);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0 || key_valid !== 1'b1 || round_num !== 4'd0)
      $display("FAIL next_dropped: got b%b v%b r%0d want b0 v1 r0", busy, key_valid, round_num);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sub();
    int lat;
    logic [127:0] k;
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (round_key !== 128'h0 || round_num !== 4'd0 ||
        {key_valid, busy, last_round} !== 3'b000)
      $display("FAIL async_reset: got %h r%0d v%b b%b l%b want all zero",
               round_key, round_num, key_valid, busy, last_round);
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    next_key = 1'b1;
    step();
    next_key = 1'b0;
    step();
    total_cnt++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || round_key !== 128'h0)
      $display("FAIL idle_after_reset: got %h v%b b%b want 0 v0 b0", round_key, key_valid, busy);
    else pass_cnt++;
    k = rand_key();
    load_key(k);
    do_advance(lat);
    total_cnt++;
    if (lat !== 5 || round_key !== ref_key(k, 1) || round_num !== 4'd1)
      $display("FAIL post_reset_advance: got %h r%0d lat %0d want %h r1 lat 5",
               round_key, round_num, lat, ref_key(k, 1));
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    key_load = 1'b0;
    next_key = 1'b0;
    cipher_key = '0;
    init_model();
    test_reset();
    test_fips_vector();
    test_all_rounds();
    test_random_keys();
    test_next_during_sub();
    test_load_abort();
    test_load_and_next();
    test_reset_mid_sub();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
